exe_unit_wb_arbiter: RTL and testbench
======================================

// Module: exe_unit_wb_arbiter
// PURPOSE
//  Arbitrates completed results from the execute-stage functional units into the single EX/MEM
//  entry. Units: ALU, MUL, DIV, FP, FADD_SUB, FMUL, FDIV, FSQRT, R4. Requester index == riscv_types::priority_t code.
//  Fixed priority (lowest code wins) with aging: a requester waiting MAX_WAIT cycles is promoted
//  to a round-robin starved class. One registered output stage with valid/ready to the EX/MEM register.
// PARAMETERS
//  NUM_REQ   10   number of requesters; bit i <-> priority_t value i (index 7 = DEFAULT_unit, normally tied 0)
//  DATA_W    152  payload width (packed exe_p_mux_bus_type)
//  MAX_WAIT  8    cycles a valid, ungranted request waits before it is starved; 0 => pure round-robin
//  CNT_W     $clog2(MAX_WAIT+1)  wait-counter width (derived)
// PORTS
//  clk        in   1               clock
//  reset      in   1               synchronous, active-high reset
//  req_valid  in   NUM_REQ         unit i has a completed result
//  req_data   in   NUM_REQ*DATA_W  unit i payload at [i*DATA_W +: DATA_W]
//  req_ready  out  NUM_REQ         one-hot/zero grant; transfer when req_valid[i] & req_ready[i]
//  out_valid  out  1               registered result valid toward EX/MEM
//  out_data   out  DATA_W          registered winning payload
//  out_unit   out  4               priority_t of the winning unit
//  out_ready  in   1               EX/MEM can accept (~stall)
//  starved    out  NUM_REQ         registered: wait_cnt[i] >= MAX_WAIT and req_valid[i] (debug/perf)
// BEHAVIOUR
//  - Reset values: out_valid=0; out_data=0; out_unit=DEFAULT_unit (4'd7); wait_cnt[*]=0; rr_ptr=0; starved=0.
//    req_ready is forced 0 while reset=1.
//  - accept = ~out_valid | out_ready. req_ready is nonzero only when accept=1 and at least one req_valid=1.
//  - Winner selection, combinational from current cycle inputs:
//    - S = {i : req_valid[i] & wait_cnt[i] >= MAX_WAIT}.
//    - If S is nonempty: winner = first i in S scanning rr_ptr, rr_ptr+1, ..., wrapping at NUM_REQ.
//    - Otherwise: winner = lowest i with req_valid[i] (FDIV_unit highest priority).
//  - On accept & winner exists: req_ready[winner]=1 in the same cycle. Next edge: out_data<=req_data[winner],
//    out_unit<=winner, out_valid<=1.
//    - If the winner came from S: rr_ptr <= (winner+1) mod NUM_REQ. Otherwise rr_ptr holds.
//  - On accept & no req_valid: out_valid<=0; out_data and out_unit hold.
//  - On ~accept (out_valid=1, out_ready=0): req_ready=0; out_valid, out_data and out_unit hold stable.
//  - Latency: 1 cycle from transfer to out_valid. Throughput is 1/cycle when out_ready is held at 1.
//    Simultaneous out_ready and new request gives a back-to-back handoff with no bubble.
//  - wait_cnt[i]:
//    - 0 when req_valid[i]=0 or unit i transfers this cycle.
//    - Otherwise +1, saturating at MAX_WAIT.
//    - Counts during ~accept cycles as well.
//  - Requester rule: once req_valid[i]=1, valid and data stay stable until transfer. The bench asserts this.
//    The arbiter never revokes a grant.
//  - NUM_REQ=1 degenerates to a registered pipe. MAX_WAIT=0 puts every valid in S, giving pure round-robin.
//  - Reset mid-operation: a pending output is discarded and all counters and the pointer are cleared at the next edge.
//  - No X propagation: out_data/out_unit change only on a transfer.
// TESTING
//  1. reset=1 for 2 cycles, req_valid=10'h3FF -> req_ready=0, out_valid=0, out_unit=7 during and after.
//  2. req_valid bits {2,4,6} held, out_ready=1 -> grants 2,4,6 on consecutive cycles.
//     out_unit 2,4,6 one cycle later, with out_data matching each payload.
//  3. out_valid=1, out_ready=0 for 5 cycles with req 1 pending -> req_ready=0, out_data stable.
//     The cycle out_ready=1, req_ready[1]=1.
//  4. MAX_WAIT=8; unit 0 re-presents valid every cycle, unit 6 valid from cycle 0 -> unit 6 granted by cycle 8.
//     Then unit 0 resumes; unit 6 wait_cnt cleared.
//  5. Units 3 and 9 starved together with rr_ptr=5 -> grant 9 (rr_ptr->0), then 3 (rr_ptr->4).
//  6. Reset asserted one cycle while out_valid=1, out_ready=0 and wait_cnt[2]=5 -> next cycle out_valid=0,
//     wait_cnt=0, rr_ptr=0.

Source files
------------

// File: rtl/exe_unit_wb_arbiter.sv
// exe_unit_wb_arbiter: merges execute-unit results into the EX/MEM entry.
// Fixed priority with aging into a round-robin starved class; one output register.
module exe_unit_wb_arbiter #(
  parameter int NUM_REQ  = 10,
  parameter int DATA_W   = 152,
  parameter int MAX_WAIT = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [3:0]                out_unit,
  input  logic                      out_ready,
  output logic [NUM_REQ-1:0]        starved
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int IDX_W = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [3:0]         out_unit_q, out_unit_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] starved_q, starved_d;
  logic [CNT_W-1:0]   wait_cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   wait_cnt_d [NUM_REQ];

  logic               accept;
  logic               win_found;
  logic               win_aged;
  logic               grant;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   scan_idx;
  logic [NUM_REQ-1:0] aged;
  logic [NUM_REQ-1:0] grant_vec;
  logic [DATA_W-1:0]  win_data;

  always_comb begin
    accept    = ~out_valid_q | out_ready;
    win_found = 1'b0;
    win_aged  = 1'b0;
    win_idx   = '0;
    scan_idx  = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++)
      aged[i] = req_valid[i] && (wait_cnt_q[i] >= CNT_MAX);
    // aged requesters share a rotating pointer; otherwise lowest index wins
    if (|aged) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!win_found && aged[scan_idx]) begin
          win_found = 1'b1;
          win_aged  = 1'b1;
          win_idx   = scan_idx;
        end
        scan_idx = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end
    grant     = accept & win_found & ~reset;
    grant_vec = '0;
    win_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        grant_vec[i] = grant;
        win_data     = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_unit_d  = out_unit_q;
    rr_ptr_d    = rr_ptr_q;
    starved_d   = aged;
    if (accept) begin
      out_valid_d = win_found;
      if (win_found) begin
        out_data_d = win_data;
        out_unit_d = 4'(win_idx);
      end
    end
    if (grant && win_aged)
      rr_ptr_d = (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req_valid[i] || grant_vec[i])
        wait_cnt_d[i] = '0;
      else if (wait_cnt_q[i] >= CNT_MAX)
        wait_cnt_d[i] = CNT_MAX;
      else
        wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_unit_q  <= 4'd7;
      rr_ptr_q    <= '0;
      starved_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++)
        wait_cnt_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_unit_q  <= out_unit_d;
      rr_ptr_q    <= rr_ptr_d;
      starved_q   <= starved_d;
      for (int i = 0; i < NUM_REQ; i++)
        wait_cnt_q[i] <= wait_cnt_d[i];
    end
  end

  assign req_ready = grant_vec;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_unit  = out_unit_q;
  assign starved   = starved_q;

endmodule

// File: tb/tb_exe_unit_wb_arbiter.sv
// tb_exe_unit_wb_arbiter: directed scenarios plus random traffic
// compared against a behavioural model of the arbitration rules.
module tb_exe_unit_wb_arbiter;

  localparam int N  = 10;
  localparam int W  = 152;
  localparam int MW = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           out_ready = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [3:0]     out_unit;
  logic [N-1:0]   starved;

  logic [N-1:0]   vld = '0;
  logic [W-1:0]   dat [N];

  int passed = 0;
  int total  = 0;

  // model state
  int           m_wait [N];
  int           m_rr = 0;
  logic         m_ov = 1'b0;
  logic [W-1:0] m_od = '0;
  int           m_ou = 7;
  logic [N-1:0] m_st = '0;

  always #5 clk = ~clk;

  always_comb begin
    req_valid = vld;
    for (int i = 0; i < N; i++)
      req_data[i*W +: W] = dat[i];
  end

  exe_unit_wb_arbiter #(
    .NUM_REQ(N), .DATA_W(W), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_unit(out_unit),
    .out_ready(out_ready), .starved(starved)
  );

  function automatic logic [W-1:0] rnd_data();
    return W'({$urandom(), $urandom(), $urandom(),
               $urandom(), $urandom()});
  endfunction

  // winner this cycle, -1 when nothing transfers
  function automatic int m_win();
    if (reset || (m_ov && !out_ready)) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (vld[i] && m_wait[i] >= MW) return i;
    end
    for (int i = 0; i < N; i++)
      if (vld[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int w = m_win();
    logic [N-1:0] r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    int w = m_win();
    logic [N-1:0] s = '0;
    for (int i = 0; i < N; i++)
      s[i] = vld[i] && (m_wait[i] >= MW);
    if (reset) begin
      m_ov = 1'b0; m_od = '0; m_ou = 7; m_rr = 0; m_st = '0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
    end else begin
      m_st = s;
      if (!m_ov || out_ready) begin
        m_ov = (w >= 0);
        if (w >= 0) begin
          m_od = dat[w];
          m_ou = w;
          if (s[w]) m_rr = (w + 1) % N;
        end
      end
      for (int i = 0; i < N; i++)
        if (!vld[i] || i == w) m_wait[i] = 0;
        else m_wait[i] = (m_wait[i] < MW) ? m_wait[i] + 1 : MW;
    end
  endtask

  task automatic consume(input int w, input bit refill0);
    if (w < 0) return;
    if (refill0 && w == 0) dat[0] = rnd_data();
    else vld[w] = 1'b0;
  endtask

  task automatic test_reset();
    logic [N-1:0] er;
    reset = 1'b1; out_ready = 1'b1; vld = '1;
    for (int i = 0; i < N; i++) dat[i] = rnd_data();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin reset = 1'b0; vld = '0; end
      @(negedge clk);
      er = m_ready();
      total++;
      if (req_ready !== er)
        $display("FAIL reset_ready got %h want %h", req_ready, er);
      else passed++;
      @(posedge clk); model_edge(); #1;
      total++;
      if (out_valid !== 1'b0 || out_unit !== 4'd7 || starved !== '0)
        $display("FAIL reset_out got v=%b u=%0d s=%h want v=0 u=7 s=0",
                 out_valid, out_unit, starved);
      else passed++;
    end
  endtask

  task automatic test_priority();
    logic [N-1:0] er;
    int w;
    out_ready = 1'b1;
    foreach (vld[i]) if (i == 2 || i == 4 || i == 6) begin
      vld[i] = 1'b1; dat[i] = rnd_data();
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      er = m_ready(); w = m_win();
      total++;
      if (req_ready !== er)
        $display("FAIL prio_ready c%0d got %h want %h", c, req_ready, er);
      else passed++;
      @(posedge clk); model_edge(); #1;
      total++;
      if (out_valid !== m_ov || out_unit !== 4'(m_ou) || out_data !== m_od)
        $display("FAIL prio_out c%0d got v=%b u=%0d d=%h want v=%b u=%0d d=%h",
                 c, out_valid, out_unit, out_data, m_ov, m_ou, m_od);
      else passed++;
      consume(w, 1'b0);
    end
  endtask

  task automatic test_stall();
    logic [N-1:0] er;
    int w;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin vld[5] = 1'b1; dat[5] = rnd_data(); out_ready = 1'b1; end
      if (c == 1) begin vld[1] = 1'b1; dat[1] = rnd_data(); out_ready = 1'b0; end
      if (c == 6) out_ready = 1'b1;
      @(negedge clk);
      er = m_ready(); w = m_win();
      total++;
      if (req_ready !== er)
        $display("FAIL stall_ready c%0d got %h want %h", c, req_ready, er);
      else passed++;
      if (c == 6) begin
        total++;
        if (req_ready[1] !== 1'b1)
          $display("FAIL stall_release got %b want 1", req_ready[1]);
        else passed++;
      end
      @(posedge clk); model_edge(); #1;
      total++;
      if (out_valid !== m_ov || out_unit !== 4'(m_ou) || out_data !== m_od)
        $display("FAIL stall_out c%0d got v=%b u=%0d d=%h want v=%b u=%0d d=%h",
                 c, out_valid, out_unit, out_data, m_ov, m_ou, m_od);
      else passed++;
      consume(w, 1'b0);
    end
  endtask

  task automatic test_aging();
    logic [N-1:0] er;
    int w;
    int g6 = -1;
    out_ready = 1'b1;
    vld[0] = 1'b1; dat[0] = rnd_data();
    vld[6] = 1'b1; dat[6] = rnd_data();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      er = m_ready(); w = m_win();
      if (req_ready[6] === 1'b1 && g6 < 0) g6 = c;
      total++;
      if (req_ready !== er)
        $display("FAIL aging_ready c%0d got %h want %h", c, req_ready, er);
      else passed++;
      @(posedge clk); model_edge(); #1;
      total++;
      if (out_valid !== m_ov || out_unit !== 4'(m_ou) || out_data !== m_od)
        $display("FAIL aging_out c%0d got v=%b u=%0d want v=%b u=%0d",
                 c, out_valid, out_unit, m_ov, m_ou);
      else passed++;
      consume(w, 1'b1);
      if (g6 >= 0 && c >= g6 + 2) break;
    end
    total++;
    if (g6 !== 8) $display("FAIL aging_cycle got %0d want 8", g6);
    else passed++;
  endtask

  task automatic test_rr();
    logic [N-1:0] er;
    int w;
    int q[$];
    out_ready = 1'b1;
    vld[3] = 1'b1; dat[3] = rnd_data();
    vld[9] = 1'b1; dat[9] = rnd_data();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      er = m_ready(); w = m_win();
      if (req_ready[9] === 1'b1) q.push_back(9);
      if (req_ready[3] === 1'b1) q.push_back(3);
      total++;
      if (req_ready !== er)
        $display("FAIL rr_ready c%0d got %h want %h", c, req_ready, er);
      else passed++;
      @(posedge clk); model_edge(); #1;
      total++;
      if (out_valid !== m_ov || out_unit !== 4'(m_ou) || out_data !== m_od)
        $display("FAIL rr_out c%0d got v=%b u=%0d want v=%b u=%0d",
                 c, out_valid, out_unit, m_ov, m_ou);
      else passed++;
      consume(w, 1'b1);
      if (q.size() >= 2) break;
    end
    total++;
    if (q.size() < 2 || q[0] != 9 || q[1] != 3)
      $display("FAIL rr_order got %p want '{9,3}", q);
    else passed++;
    vld = '0;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] er;
    int w;
    int g2 = -1;
    for (int c = 0; c < 30; c++) begin
      if (c == 0) begin vld[4] = 1'b1; dat[4] = rnd_data(); out_ready = 1'b1; end
      if (c == 1) begin vld[2] = 1'b1; dat[2] = rnd_data(); out_ready = 1'b0; end
      if (c == 6) reset = 1'b1;
      if (c == 7) begin
        reset = 1'b0; out_ready = 1'b1;
        vld[0] = 1'b1; dat[0] = rnd_data();
      end
      @(negedge clk);
      er = m_ready(); w = m_win();
      if (c >= 7 && req_ready[2] === 1'b1 && g2 < 0) g2 = c - 7;
      total++;
      if (req_ready !== er)
        $display("FAIL rstmid_ready c%0d got %h want %h", c, req_ready, er);
      else passed++;
      @(posedge clk); model_edge(); #1;
      total++;
      if (out_valid !== m_ov || out_unit !== 4'(m_ou) || out_data !== m_od)
        $display("FAIL rstmid_out c%0d got v=%b u=%0d want v=%b u=%0d",
                 c, out_valid, out_unit, m_ov, m_ou);
      else passed++;
      if (c == 6) begin
        total++;
        if (out_valid !== 1'b0)
          $display("FAIL rstmid_drop got %b want 0", out_valid);
        else passed++;
      end
      consume(w, 1'b1);
      if (g2 >= 0) break;
    end
    total++;
    if (g2 !== 8) $display("FAIL rstmid_wait got %0d want 8", g2);
    else passed++;
    vld = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    int w;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!vld[i] && $urandom_range(3) == 0) begin
          vld[i] = 1'b1; dat[i] = rnd_data();
        end
      out_ready = ($urandom_range(3) != 0);
      reset = ($urandom_range(99) == 0);
      @(negedge clk);
      er = m_ready(); w = m_win();
      total++;
      if (req_ready !== er)
        $display("FAIL rand_ready c%0d got %h want %h", c, req_ready, er);
      else passed++;
      @(posedge clk); model_edge(); #1;
      total++;
      if (out_valid !== m_ov || out_unit !== 4'(m_ou) || out_data !== m_od)
        $display("FAIL rand_out c%0d got v=%b u=%0d want v=%b u=%0d",
                 c, out_valid, out_unit, m_ov, m_ou);
      else passed++;
      total++;
      if (starved !== m_st)
        $display("FAIL rand_starved c%0d got %h want %h", c, starved, m_st);
      else passed++;
      consume(w, 1'b0);
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      dat[i] = '0;
      m_wait[i] = 0;
    end
    test_reset();
    test_priority();
    test_stall();
    test_aging();
    test_rr();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
